// File: rtl/fib_job_sequencer_if.sv
// Requester-side bundle of the Fibonacci job sequencer: requests with their
// packed N operands, grants, results and the done/ack handshake.
interface fib_job_sequencer_if #(
  parameter int NREQ = 2,
  parameter int N_W  = 6,
  parameter int D_W  = 32
);
  logic [NREQ-1:0]     req;
  logic [NREQ*N_W-1:0] req_n;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic [D_W-1:0]      result;

  modport master (output req, req_n, ack, input gnt, done, result);
  modport slave  (input req, req_n, ack, output gnt, done, result);
endinterface

// File: rtl/fib_job_sequencer.sv
// Round-robin controller that shares one Fibonacci datapath among NREQ
// requesters, sequencing load/iterate phases and returning F(N) per job.
module fib_job_sequencer #(
  parameter int NREQ = 2,
  parameter int N_W  = 6,
  parameter int D_W  = 32
) (
  input  logic           clock,
  input  logic           reset,
  fib_job_sequencer_if.slave bus,
  output logic           busy,
  output logic           dp_en_n,
  output logic           dp_select,
  output logic           dp_en_reg1,
  output logic           dp_en_reg2,
  input  logic [D_W-1:0] dp_fib
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, RESP} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] ptr, idx, pick, cand;
  logic [IDX_W:0]   sum;
  logic             found;
  logic [N_W-1:0]   n_lat, cnt;
  logic [D_W-1:0]   result_q;
  logic [NREQ-1:0]  idx_onehot;

  // First set request at or above ptr, wrapping to zero.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NREQ))
        sum = sum - (IDX_W+1)'(NREQ);
      cand = sum[IDX_W-1:0];
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = LOAD;
      LOAD:    state_next = (n_lat == '0) ? CAPTURE : RUN;
      RUN:     if (cnt == n_lat - N_W'(1)) state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (bus.ack[idx]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    idx_onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    bus.gnt    = '0;
    bus.done   = '0;
    busy       = 1'b0;
    dp_en_n    = 1'b0;
    dp_select  = 1'b0;
    dp_en_reg1 = 1'b0;
    dp_en_reg2 = 1'b0;
    if (state != IDLE) begin
      bus.gnt = idx_onehot;
      busy    = 1'b1;
    end
    case (state)
      LOAD: begin
        dp_en_n    = 1'b1;
        dp_select  = 1'b1;
        dp_en_reg1 = 1'b1;
        dp_en_reg2 = 1'b1;
      end
      RUN: begin
        dp_en_reg1 = 1'b1;
        dp_en_reg2 = 1'b1;
      end
      RESP:    bus.done = idx_onehot;
      default: ;
    endcase
  end

  assign bus.result = result_q;

  // The index and N are latched at grant so later req/req_n changes are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      n_lat    <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (found) begin
          idx   <= pick;
          n_lat <= bus.req_n[int'(pick)*N_W +: N_W];
        end
        LOAD:    cnt <= '0;
        RUN:     cnt <= cnt + N_W'(1);
        CAPTURE: result_q <= dp_fib;
        RESP: if (bus.ack[idx])
          ptr <= (idx == IDX_W'(NREQ-1)) ? '0 : idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_job_sequencer.sv
// Directed bench for fib_job_sequencer with a behavioural Fibonacci datapath;
// expected results and cycle numbers are hand-computed constants.
module tb_fib_job_sequencer;

  localparam int NREQ = 2;
  localparam int N_W  = 6;
  localparam int D_W  = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           busy, dp_en_n, dp_select, dp_en_reg1, dp_en_reg2;
  logic [D_W-1:0] reg1 = '0;
  logic [D_W-1:0] reg2 = '0;
  int             checks = 0;
  int             passes = 0;

  fib_job_sequencer_if #(.NREQ(NREQ), .N_W(N_W), .D_W(D_W)) bus ();

  fib_job_sequencer #(.NREQ(NREQ), .N_W(N_W), .D_W(D_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .dp_en_n    (dp_en_n),
    .dp_select  (dp_select),
    .dp_en_reg1 (dp_en_reg1),
    .dp_en_reg2 (dp_en_reg2),
    .dp_fib     (reg1)
  );

  always #5 clock = ~clock;

  // Datapath model: select=1 loads (0,1), select=0 iterates.
  always @(posedge clock) begin
    if (dp_en_reg1) reg1 <= dp_select ? '0 : reg2;
    if (dp_en_reg2) reg2 <= dp_select ? D_W'(1) : reg1 + reg2;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0; bus.req_n = '0; bus.ack = '0;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done == '0 && cyc < 300) begin
      step(1);
      cyc++;
    end
  endtask

  task automatic finish_job(input int i);
    bus.ack[i] = 1'b1;
    bus.req[i] = 1'b0;
    step(1);
    bus.ack = '0;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_n = '0; bus.ack = '0;
    reset = 1'b0;
    step(2);
    checks++; if (bus.gnt !== 2'b00) $display("[TB] FAIL reset_gnt got %b want 00", bus.gnt); else passes++;
    checks++; if (bus.done !== 2'b00) $display("[TB] FAIL reset_done got %b want 00", bus.done); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (bus.result !== 32'd0) $display("[TB] FAIL reset_result got %0d want 0", bus.result); else passes++;
    checks++; if ({dp_en_n, dp_select, dp_en_reg1, dp_en_reg2} !== 4'b0000)
      $display("[TB] FAIL reset_dp got %b want 0000", {dp_en_n, dp_select, dp_en_reg1, dp_en_reg2}); else passes++;
    reset = 1'b1;
  endtask

  task automatic test_single();
    int cyc;
    bus.req_n = {6'd0, 6'd10};
    bus.req   = 2'b01;
    step(1);
    checks++; if (bus.gnt !== 2'b01) $display("[TB] FAIL single_gnt_c1 got %b want 01", bus.gnt); else passes++;
    checks++; if ({busy, dp_en_n, dp_select} !== 3'b111) $display("[TB] FAIL single_load got %b want 111", {busy, dp_en_n, dp_select}); else passes++;
    step(1);
    checks++; if ({dp_en_n, dp_select, dp_en_reg1, dp_en_reg2} !== 4'b0011)
      $display("[TB] FAIL single_run got %b want 0011", {dp_en_n, dp_select, dp_en_reg1, dp_en_reg2}); else passes++;
    wait_done(cyc);
    cyc += 2;
    checks++; if (cyc !== 13) $display("[TB] FAIL single_done_cycle got %0d want 13", cyc); else passes++;
    checks++; if (bus.done !== 2'b01) $display("[TB] FAIL single_done got %b want 01", bus.done); else passes++;
    checks++; if (bus.result !== 32'd55) $display("[TB] FAIL single_result got %0d want 55", bus.result); else passes++;
    finish_job(0);
    checks++; if ({busy, bus.gnt, bus.done} !== 5'b0) $display("[TB] FAIL single_after_ack got %b want 00000", {busy, bus.gnt, bus.done}); else passes++;
  endtask

  task automatic test_boundary();
    int cyc;
    bus.req_n = {6'd0, 6'd0}; bus.req = 2'b01;
    wait_done(cyc);
    checks++; if (cyc !== 3) $display("[TB] FAIL n0_cycle got %0d want 3", cyc); else passes++;
    checks++; if (bus.result !== 32'd0) $display("[TB] FAIL n0_result got %0d want 0", bus.result); else passes++;
    finish_job(0);
    bus.req_n = {6'd0, 6'd1}; bus.req = 2'b01;
    wait_done(cyc);
    checks++; if (cyc !== 4) $display("[TB] FAIL n1_cycle got %0d want 4", cyc); else passes++;
    checks++; if (bus.result !== 32'd1) $display("[TB] FAIL n1_result got %0d want 1", bus.result); else passes++;
    finish_job(0);
    bus.req_n = {6'd0, 6'd2}; bus.req = 2'b01;
    wait_done(cyc);
    checks++; if (cyc !== 5) $display("[TB] FAIL n2_cycle got %0d want 5", cyc); else passes++;
    checks++; if (bus.result !== 32'd1) $display("[TB] FAIL n2_result got %0d want 1", bus.result); else passes++;
    finish_job(0);
  endtask

  task automatic test_contention();
    int cyc;
    do_reset();
    bus.req_n = {6'd7, 6'd5}; bus.req = 2'b11;
    wait_done(cyc);
    checks++; if (bus.done !== 2'b01) $display("[TB] FAIL cont_first_done got %b want 01", bus.done); else passes++;
    checks++; if (bus.result !== 32'd5) $display("[TB] FAIL cont_first_result got %0d want 5", bus.result); else passes++;
    finish_job(0);
    checks++; if (bus.gnt !== 2'b00) $display("[TB] FAIL cont_idle_gap got %b want 00", bus.gnt); else passes++;
    step(1);
    checks++; if (bus.gnt !== 2'b10) $display("[TB] FAIL cont_second_gnt got %b want 10", bus.gnt); else passes++;
    wait_done(cyc);
    checks++; if (bus.done !== 2'b10) $display("[TB] FAIL cont_second_done got %b want 10", bus.done); else passes++;
    checks++; if (bus.result !== 32'd13) $display("[TB] FAIL cont_second_result got %0d want 13", bus.result); else passes++;
    finish_job(1);
    bus.req = 2'b11;
    wait_done(cyc);
    checks++; if (bus.done !== 2'b01) $display("[TB] FAIL cont_ptr0_done got %b want 01", bus.done); else passes++;
    bus.req = 2'b00;
    finish_job(0);
    bus.req = 2'b11;
    wait_done(cyc);
    checks++; if (bus.done !== 2'b10) $display("[TB] FAIL cont_ptr1_done got %b want 10", bus.done); else passes++;
    checks++; if (bus.result !== 32'd13) $display("[TB] FAIL cont_ptr1_result got %0d want 13", bus.result); else passes++;
    bus.req = 2'b00;
    finish_job(1);
  endtask

  task automatic test_delayed_ack();
    int cyc;
    bus.req_n = {6'd3, 6'd6}; bus.req = 2'b11;
    wait_done(cyc);
    checks++; if (bus.result !== 32'd8) $display("[TB] FAIL hold_result got %0d want 8", bus.result); else passes++;
    for (int i = 0; i < 4; i++) begin
      bus.ack = (i == 1) ? 2'b10 : 2'b00;
      step(1);
      checks++; if ({bus.gnt, bus.done} !== 4'b0101) $display("[TB] FAIL hold_%0d_gnt_done got %b want 0101", i, {bus.gnt, bus.done}); else passes++;
      checks++; if (bus.result !== 32'd8) $display("[TB] FAIL hold_%0d_result got %0d want 8", i, bus.result); else passes++;
    end
    bus.ack = '0;
    finish_job(0);
    checks++; if ({bus.gnt, bus.done} !== 4'b0000) $display("[TB] FAIL hold_closed got %b want 0000", {bus.gnt, bus.done}); else passes++;
    wait_done(cyc);
    checks++; if (bus.done !== 2'b10) $display("[TB] FAIL hold_next_done got %b want 10", bus.done); else passes++;
    checks++; if (bus.result !== 32'd2) $display("[TB] FAIL hold_next_result got %0d want 2", bus.result); else passes++;
    finish_job(1);
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bus.req_n = {6'd0, 6'd20}; bus.req = 2'b01;
    step(8);
    checks++; if ({busy, dp_en_reg1} !== 2'b11) $display("[TB] FAIL midrun_active got %b want 11", {busy, dp_en_reg1}); else passes++;
    reset = 1'b0;
    #1;
    checks++; if ({bus.gnt, bus.done, busy} !== 5'b0) $display("[TB] FAIL midrun_reset_out got %b want 00000", {bus.gnt, bus.done, busy}); else passes++;
    checks++; if ({dp_en_n, dp_select, dp_en_reg1, dp_en_reg2} !== 4'b0000)
      $display("[TB] FAIL midrun_reset_dp got %b want 0000", {dp_en_n, dp_select, dp_en_reg1, dp_en_reg2}); else passes++;
    bus.req = '0;
    step(1);
    reset = 1'b1;
    bus.req_n = {6'd0, 6'd3}; bus.req = 2'b01;
    wait_done(cyc);
    checks++; if (cyc !== 6) $display("[TB] FAIL after_reset_cycle got %0d want 6", cyc); else passes++;
    checks++; if (bus.result !== 32'd2) $display("[TB] FAIL after_reset_result got %0d want 2", bus.result); else passes++;
    finish_job(0);
  endtask

  task automatic test_wrap();
    int cyc;
    bus.req_n = {6'd0, 6'd47}; bus.req = 2'b01;
    wait_done(cyc);
    checks++; if (cyc !== 50) $display("[TB] FAIL n47_cycle got %0d want 50", cyc); else passes++;
    checks++; if (bus.result !== 32'd2971215073) $display("[TB] FAIL n47_result got %0d want 2971215073", bus.result); else passes++;
    finish_job(0);
    bus.req_n = {6'd0, 6'd48}; bus.req = 2'b01;
    wait_done(cyc);
    checks++; if (bus.result !== 32'd512559680) $display("[TB] FAIL n48_result got %0d want 512559680", bus.result); else passes++;
    finish_job(0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_contention();
    test_delayed_ack();
    test_reset_mid_run();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fib_job_sequencer.md
# fib_job_sequencer

Controller that shares one Fibonacci datapath (two enabled registers, an adder, an N register and a select mux) among NREQ requesters. It arbitrates requests round-robin and sequences the datapath through load and iterate phases. It counts iterations internally, so no external stop signal is needed. It returns each result to its requester over a done/ack handshake. It sits between the requester ports and the datapath enable/select inputs.

## Interface
- NREQ, 2: number of requesters, legal range 2..4.
- N_W, 6: width of the requested index N.
- D_W, 32: datapath and result width.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low.
- req  input  NREQ  per-requester level request.
- req_n  input  NREQ*N_W  packed N operands; slice i belongs to req[i].
- ack  input  NREQ  per-requester result acknowledge.
- gnt  output  NREQ  one-hot grant, held from grant until ack.
- done  output  NREQ  one-hot result valid, held until ack.
- result  output  D_W  registered F(N) of the granted job.
- busy  output  1  high in any state except IDLE.
- dp_en_n  output  1  load N register.
- dp_select  output  1  1 selects initial values (reg1=0, reg2=1); 0 selects the iterate path (reg1<=reg2, reg2<=reg1+reg2).
- dp_en_reg1  output  1  reg1 enable.
- dp_en_reg2  output  1  reg2 enable.
- dp_fib  input  D_W  datapath reg1 output.

## Operation
- States: IDLE, LOAD, RUN, CAPTURE, RESP. The state is registered; all outputs except result are decoded from the state and the latched index only.
- IDLE:
  - Outputs: all datapath controls 0, busy 0.
  - If any req is set, pick the first set bit searching from ptr upward with wrap.
  - Latch that index as idx and its N, then go to LOAD.
- LOAD:
  - Outputs: dp_en_n=1, dp_select=1, dp_en_reg1=dp_en_reg2=1; cnt is cleared.
  - If N==0 go to CAPTURE, else go to RUN.
- RUN:
  - Outputs: dp_select=0, dp_en_reg1=dp_en_reg2=1; cnt increments each cycle.
  - When cnt==N-1 go to CAPTURE. This gives exactly N iterate cycles.
- CAPTURE:
  - All enables are 0.
  - result<=dp_fib on the clock edge, then go to RESP.
- RESP:
  - done[idx]=1; result is held.
  - On ack[idx]=1: ptr<=(idx+1) mod NREQ, then go to IDLE.
- gnt[idx] is 1 in LOAD, RUN, CAPTURE and RESP, and 0 in IDLE.
- Ignored inputs:
  - ack bits other than ack[idx].
  - ack in any state other than RESP.
  - req changes and req_n changes after the grant; the latched N is used.
  - Dropping req mid-job does not abort the job; done is still raised and waits for ack.
- Arithmetic belongs to the datapath and wraps modulo 2^D_W. The controller performs no overflow detection.
- Reset values: state=IDLE, ptr=0, cnt=0, idx=0, result=0, and every output is 0.

## Timing
- Cycle numbering: request sampled in IDLE at cycle 0.
  - gnt is high from cycle 1 (LOAD).
  - RUN occupies cycles 2..N+1.
  - CAPTURE is cycle N+2.
  - done is high from cycle N+3.
- N=0 gives done at cycle 3.
- ack seen in the first RESP cycle: done and gnt are 0 the next cycle (IDLE). The earliest new gnt comes one cycle after that, so a back-to-back job costs one IDLE cycle.
- Reset assertion takes effect immediately at any point, including mid-RUN or RESP. All outputs go to 0 with no clock edge required; the job is lost.
- Reset deassertion is synchronised externally; the first arbitration happens on the first clock edge after release.
- Simultaneous requests: only one grant is issued per IDLE cycle. The losing requester keeps req high and is served next because ptr has advanced.

## Test plan
- Single job, N=10 on req[0]: gnt=01 from cycle 1, done=01 at cycle 13, result=55, busy 0 after ack.
- Boundary N values:
  - N=0: result=0, done at cycle 3.
  - N=1: result=1, done at cycle 4.
  - N=2: result=1.
- Contention: req=11 with N0=5, N1=7 right after reset → req0 served first (result 5), then req1 (result 13). Repeat req=11 with ptr=0 → req0 first again. A new req=11 arriving while ptr=1 → req1 first.
- Delayed handshake, N=6:
  - ack withheld 4 cycles → done and result=8 held, no new grant despite pending req[1].
  - ack[1] pulse during RESP is ignored.
  - ack[0] closes the job.
- Reset mid-RUN (N=20, reset low at cycle 8) → gnt, done, busy and enables are 0 immediately. After release, a job with N=3 returns 2.
- Width wrap: N=47 → result 2971215073; N=48 → 512559680 (mod 2^32).
